cellrv32_wdt_hbsup: RTL and testbench

Heartbeat supervisor that decides when the watchdog timer (WDT) may be fed. It collects per-source heartbeat pulses from up to 8 requesters (software tasks or hardware agents) inside a programmable time window. It issues the WDT "feed" write on the IO bus only when every enabled source has checked in on time. On an early or late heartbeat, or a stalled bus, it stops feeding permanently, raises an interrupt and lets the WDT bite.

---
 rtl/cellrv32_wdt_hbsup.sv | 193 +++++++++++++++++++
 tb/tb_cellrv32_wdt_hbsup.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_wdt_hbsup.sv
// Heartbeat supervisor: feeds the WDT only when every enabled source checked in
// inside the [win_min, win_max] tick window; any violation stops feeding for good.
module cellrv32_wdt_hbsup #(
  parameter int          NUM_SRC  = 4,
  parameter int          WIN_W    = 16,
  parameter logic [31:0] WDT_ADDR = 32'hFFFF_FFBC,
  parameter int          ACK_TMO  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               tick_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  input  logic [NUM_SRC-1:0] hb_i,
  input  logic [WIN_W-1:0]   win_min_i,
  input  logic [WIN_W-1:0]   win_max_i,
  input  logic [31:0]        wdt_cfg_i,
  output logic [31:0]        addr_o,
  output logic               wren_o,
  output logic [31:0]        data_o,
  input  logic               ack_i,
  output logic [NUM_SRC-1:0] seen_o,
  output logic               fault_o,
  output logic [1:0]         fault_cause_o,
  output logic [NUM_SRC-1:0] fault_src_o,
  output logic               irq_o,
  output logic [7:0]         feed_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_FEED, S_WAIT, S_FAULT} state_t;

  localparam logic [1:0] CAUSE_EARLY = 2'b01;
  localparam logic [1:0] CAUSE_LATE  = 2'b10;
  localparam logic [1:0] CAUSE_BUS   = 2'b11;
  localparam logic [7:0] TMO_LAST    = 8'(ACK_TMO - 1);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [NUM_SRC-1:0] seen_q, seen_d;
  logic [7:0]         tmo_q, tmo_d;
  logic               wren_q, wren_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               fault_q, fault_d;
  logic [1:0]         cause_q, cause_d;
  logic [NUM_SRC-1:0] fsrc_q, fsrc_d;
  logic               irq_q, irq_d;
  logic [7:0]         feed_cnt_q, feed_cnt_d;

  logic               below_min;
  logic [NUM_SRC-1:0] early_v, good_v, seen_nxt;
  logic               win_done, late;
  logic [WIN_W-1:0]   win_inc;

  assign below_min = (win_q < win_min_i);

  // Per-source classification: a pulse from an enabled source is either early or a valid check-in.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign early_v[k] = src_en_i[k] & hb_i[k] & below_min;
    assign good_v[k]  = src_en_i[k] & hb_i[k] & ~below_min;
  end

  assign seen_nxt = seen_q | good_v;
  assign win_done = (&(seen_nxt | ~src_en_i)) & (|src_en_i);
  assign late     = tick_i & (win_q == win_max_i) & ~win_done;
  assign win_inc  = (tick_i && (win_q != {WIN_W{1'b1}})) ? win_q + 1'b1 : win_q;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    seen_d     = seen_q;
    tmo_d      = tmo_q;
    wren_d     = 1'b0;
    addr_d     = 32'h0;
    data_d     = 32'h0;
    fault_d    = fault_q;
    cause_d    = cause_q;
    fsrc_d     = fsrc_q;
    irq_d      = 1'b0;
    feed_cnt_d = feed_cnt_q;
    case (state_q)
      S_IDLE: begin
        win_d   = '0;
        seen_d  = '0;
        fault_d = 1'b0;
        cause_d = 2'b00;
        fsrc_d  = '0;
        if (en_i) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (!en_i) begin
          state_d = S_IDLE;
          win_d   = '0;
          seen_d  = '0;
        end else if (|early_v) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = CAUSE_EARLY;
          fsrc_d  = early_v;
          irq_d   = 1'b1;
        end else if (win_done) begin
          state_d = S_FEED;
          seen_d  = seen_nxt;
          wren_d  = 1'b1;
          addr_d  = WDT_ADDR;
          data_d  = (wdt_cfg_i | 32'h0000_0010) & ~32'h0000_0020;
        end else if (late) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = CAUSE_LATE;
          fsrc_d  = '0;
          irq_d   = 1'b1;
        end else begin
          win_d  = win_inc;
          seen_d = seen_nxt;
        end
      end
      S_FEED: begin
        state_d = S_WAIT;
        tmo_d   = 8'h0;
      end
      S_WAIT: begin
        // The window restarts on the ack edge; a coincident tick is dropped.
        if (ack_i) begin
          feed_cnt_d = feed_cnt_q + 8'd1;
          seen_d     = '0;
          win_d      = '0;
          state_d    = en_i ? S_COLLECT : S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = CAUSE_BUS;
          fsrc_d  = '0;
          irq_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_FAULT: begin
        if (!en_i) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          cause_d = 2'b00;
          fsrc_d  = '0;
          seen_d  = '0;
          win_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      seen_q     <= '0;
      tmo_q      <= 8'h0;
      wren_q     <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
      fsrc_q     <= '0;
      irq_q      <= 1'b0;
      feed_cnt_q <= 8'h0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      seen_q     <= seen_d;
      tmo_q      <= tmo_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      fsrc_q     <= fsrc_d;
      irq_q      <= irq_d;
      feed_cnt_q <= feed_cnt_d;
    end
  end

  assign addr_o        = addr_q;
  assign wren_o        = wren_q;
  assign data_o        = data_q;
  assign seen_o        = seen_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign fault_src_o   = fsrc_q;
  assign irq_o         = irq_q;
  assign feed_cnt_o    = feed_cnt_q;

endmodule

// File: tb/tb_cellrv32_wdt_hbsup.sv
// Directed bench for the WDT heartbeat supervisor: feed, wrap, early/late/bus faults,
// masking and recovery, checked with immediate assertions.
module tb_cellrv32_wdt_hbsup;

  localparam logic [31:0] ADDR_EXP = 32'hFFFF_FFBC;
  localparam logic [31:0] CFG      = 32'h0000_AB2F;
  localparam logic [31:0] DATA_EXP = 32'h0000_AB1F;

  logic        clk = 1'b0;
  logic        rst, en, tick, ack;
  logic [3:0]  src_en, hb;
  logic [15:0] win_min, win_max;
  logic [31:0] cfg;
  logic [31:0] addr, data;
  logic        wren, fault, irq;
  logic [3:0]  seen, fsrc;
  logic [1:0]  cause;
  logic [7:0]  feed_cnt;

  int tests = 0;
  int fails = 0;

  cellrv32_wdt_hbsup #(.NUM_SRC(4), .WIN_W(16), .WDT_ADDR(ADDR_EXP), .ACK_TMO(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick), .src_en_i(src_en), .hb_i(hb),
    .win_min_i(win_min), .win_max_i(win_max), .wdt_cfg_i(cfg),
    .addr_o(addr), .wren_o(wren), .data_o(data), .ack_i(ack),
    .seen_o(seen), .fault_o(fault), .fault_cause_o(cause), .fault_src_o(fsrc),
    .irq_o(irq), .feed_cnt_o(feed_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    hb = m;
    step();
    hb = 4'h0;
  endtask

  // One complete window from COLLECT with counter 0: check-in at counter 3, then acked feed.
  task automatic plain_window();
    ticks(3);
    pulse(4'hF);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int wr_seen;
    rst = 1'b1; en = 1'b0; tick = 1'b0; ack = 1'b0;
    src_en = 4'hF; hb = 4'h0; win_min = 16'd2; win_max = 16'd10; cfg = CFG;
    step();
    step();
    chk("rst_wren", {31'h0, wren}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_seen", {28'h0, seen}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_cause", {30'h0, cause}, 32'h0);
    chk("rst_fsrc", {28'h0, fsrc}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_cnt", {24'h0, feed_cnt}, 32'h0);
    rst = 1'b0;

    // Normal feed
    en = 1'b1;
    step();
    ticks(3);
    pulse(4'b0011);
    chk("part_seen", {28'h0, seen}, 32'h3);
    chk("part_nowren", {31'h0, wren}, 32'h0);
    pulse(4'b1100);
    chk("feed_seen", {28'h0, seen}, 32'hF);
    chk("feed_wren", {31'h0, wren}, 32'h1);
    chk("feed_addr", addr, ADDR_EXP);
    chk("feed_data", data, DATA_EXP);
    step();
    chk("feed_once", {31'h0, wren}, 32'h0);
    chk("idle_addr", addr, 32'h0);
    chk("idle_data", data, 32'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_cnt", {24'h0, feed_cnt}, 32'h1);
    chk("ack_seen", {28'h0, seen}, 32'h0);

    // 255 more windows wrap the counter
    for (int w = 0; w < 254; w++) plain_window();
    chk("cnt_255", {24'h0, feed_cnt}, 32'hFF);
    plain_window();
    chk("cnt_wrap", {24'h0, feed_cnt}, 32'h0);

    // Early fault: source 2 at counter 1
    ticks(1);
    pulse(4'b0100);
    chk("early_fault", {31'h0, fault}, 32'h1);
    chk("early_cause", {30'h0, cause}, 32'h1);
    chk("early_src", {28'h0, fsrc}, 32'h4);
    chk("early_irq", {31'h0, irq}, 32'h1);
    step();
    chk("early_irq_off", {31'h0, irq}, 32'h0);
    chk("early_sticky", {31'h0, fault}, 32'h1);
    wr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick = 1'b1; hb = 4'hF; ack = 1'b1;
      step();
      if (wren) wr_seen++;
    end
    tick = 1'b0; hb = 4'h0; ack = 1'b0;
    chk("fault_nowrite", wr_seen, 32'h0);

    // Recovery via enable drop
    en = 1'b0;
    step();
    chk("rec_fault", {31'h0, fault}, 32'h0);
    chk("rec_cause", {30'h0, cause}, 32'h0);
    chk("rec_src", {28'h0, fsrc}, 32'h0);
    chk("rec_cnt", {24'h0, feed_cnt}, 32'h0);

    // Late fault: source 3 silent
    en = 1'b1;
    step();
    ticks(3);
    pulse(4'b0111);
    chk("late_seen", {28'h0, seen}, 32'h7);
    ticks(7);
    chk("late_pending", {31'h0, fault}, 32'h0);
    ticks(1);
    chk("late_fault", {31'h0, fault}, 32'h1);
    chk("late_cause", {30'h0, cause}, 32'h2);
    chk("late_src", {28'h0, fsrc}, 32'h0);
    chk("late_irq", {31'h0, irq}, 32'h1);
    en = 1'b0;
    step();
    en = 1'b1;
    step();

    // Last heartbeat coincides with the late tick: feed wins
    ticks(10);
    hb = 4'hF; tick = 1'b1;
    step();
    hb = 4'h0; tick = 1'b0;
    chk("edge_wren", {31'h0, wren}, 32'h1);
    chk("edge_nofault", {31'h0, fault}, 32'h0);
    step();
    // Tick on the ack edge is dropped, so one more tick leaves the counter at 1
    ack = 1'b1; tick = 1'b1;
    step();
    ack = 1'b0; tick = 1'b0;
    chk("edge_cnt", {24'h0, feed_cnt}, 32'h1);
    ticks(1);
    pulse(4'b0001);
    chk("restart_early", {30'h0, cause}, 32'h1);
    chk("restart_src", {28'h0, fsrc}, 32'h1);
    en = 1'b0;
    step();

    // Masking: sources 1 and 3 disabled
    src_en = 4'b0101;
    en = 1'b1;
    step();
    pulse(4'b1010);
    chk("mask_noearly", {31'h0, fault}, 32'h0);
    chk("mask_noseen", {28'h0, seen}, 32'h0);
    ticks(3);
    pulse(4'b0101);
    chk("mask_wren", {31'h0, wren}, 32'h1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("mask_cnt", {24'h0, feed_cnt}, 32'h2);

    // No participants: never feed, late fault at the end of the window
    src_en = 4'b0000;
    pulse(4'hF);
    ticks(10);
    chk("none_nofault", {31'h0, fault}, 32'h0);
    chk("none_nowren", {31'h0, wren}, 32'h0);
    ticks(1);
    chk("none_late", {30'h0, cause}, 32'h2);
    en = 1'b0;
    step();
    src_en = 4'hF;
    en = 1'b1;
    step();

    // Bus timeout: 16 cycles in WAIT without ack
    ticks(3);
    pulse(4'hF);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("tmo_pending", {31'h0, fault}, 32'h0);
    step();
    chk("tmo_fault", {31'h0, fault}, 32'h1);
    chk("tmo_cause", {30'h0, cause}, 32'h3);
    chk("tmo_irq", {31'h0, irq}, 32'h1);
    chk("tmo_src", {28'h0, fsrc}, 32'h0);
    en = 1'b0;
    step();
    en = 1'b1;
    step();

    // Reset in WAIT beats a coincident ack
    ticks(3);
    pulse(4'hF);
    step();
    rst = 1'b1; ack = 1'b1;
    step();
    rst = 1'b0; ack = 1'b0;
    chk("rstw_cnt", {24'h0, feed_cnt}, 32'h0);
    chk("rstw_seen", {28'h0, seen}, 32'h0);
    chk("rstw_wren", {31'h0, wren}, 32'h0);
    chk("rstw_fault", {31'h0, fault}, 32'h0);
    step();
    chk("rstw_after", {24'h0, feed_cnt}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
